// File: rtl/cache_assoc.sv
// cache_assoc: 2-way set-associative, read-only cache with a block refill FSM.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-low reset
//   req_valid/req_addr       CPU read request (word address)
//   req_ready                high in IDLE, request is latched that cycle
//   resp_valid/resp_data     one-cycle read-data strobe, data held otherwise
//   hit/miss                 one-cycle lookup result pulses
//   mem_req/mem_addr         refill request, block-aligned address
//   mem_rvalid/mem_rdata     refill beats, one word per valid beat
//   hit_cnt/miss_cnt         performance counters
//
// Optional feature: define CACHE_PERF_CNT_EN to build saturating hit/miss
// counters; otherwise hit_cnt/miss_cnt are tied to zero.
//
// Lookup results (hit, miss, resp_valid, resp_data) are decided in COMPARE and
// registered, so they appear the cycle after COMPARE: acceptance -> COMPARE ->
// response gives the two-cycle hit latency.
module cache_assoc #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              hit,
    output logic              miss,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;

    typedef enum logic [1:0] {IDLE, COMPARE, REFILL} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0]   addr_q;
    logic [SETS-1:0]     valid0, valid1;
    logic [SETS-1:0]     lru;          // way to evict next when both ways valid
    logic [TAG_W-1:0]    tag0 [SETS];
    logic [TAG_W-1:0]    tag1 [SETS];
    logic [DATA_W-1:0]   data0 [SETS*WORDS];
    logic [DATA_W-1:0]   data1 [SETS*WORDS];
    logic [OFFSET_W-1:0] beat;
    logic                victim_q;

    logic [TAG_W-1:0]    tag_a;
    logic [INDEX_W-1:0]  idx_a;
    logic [OFFSET_W-1:0] off_a;
    logic                hit0, hit1, lookup_hit, lookup_miss, victim_sel, beat_wr, last_beat;

    assign tag_a = addr_q[ADDR_W-1 -: TAG_W];
    assign idx_a = addr_q[OFFSET_W +: INDEX_W];
    assign off_a = addr_q[OFFSET_W-1:0];

    assign hit0        = valid0[idx_a] && (tag0[idx_a] == tag_a);
    assign hit1        = valid1[idx_a] && (tag1[idx_a] == tag_a);
    assign lookup_hit  = (state == COMPARE) && (hit0 || hit1);
    assign lookup_miss = (state == COMPARE) && !(hit0 || hit1);
    // Prefer filling an empty way before evicting by LRU.
    assign victim_sel  = !valid0[idx_a] ? 1'b0 : (!valid1[idx_a] ? 1'b1 : lru[idx_a]);
    // Beats arriving outside REFILL never touch the arrays.
    assign beat_wr     = (state == REFILL) && mem_rvalid;
    assign last_beat   = beat_wr && (beat == {OFFSET_W{1'b1}});

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = COMPARE;
            end
            COMPARE: state_nx = lookup_hit ? IDLE : REFILL;
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                if (last_beat) state_nx = COMPARE;  // replay the lookup
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            valid0     <= '0;
            valid1     <= '0;
            lru        <= '0;
            beat       <= '0;
            victim_q   <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            state      <= state_nx;
            hit        <= lookup_hit;
            miss       <= lookup_miss;
            resp_valid <= lookup_hit;
            if (state == IDLE && req_valid) addr_q <= req_addr;
            if (lookup_hit) begin
                resp_data  <= hit0 ? data0[{idx_a, off_a}] : data1[{idx_a, off_a}];
                lru[idx_a] <= hit0;  // point at the way not just used
            end
            if (lookup_miss) begin
                victim_q <= victim_sel;
                beat     <= '0;
            end
            if (beat_wr) begin
                beat <= beat + 1'b1;
                if (last_beat) begin
                    if (victim_q) valid1[idx_a] <= 1'b1;
                    else          valid0[idx_a] <= 1'b1;
                    lru[idx_a] <= ~victim_q;
                end
            end
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            if (victim_q) data1[{idx_a, beat}] <= mem_rdata;
            else          data0[{idx_a, beat}] <= mem_rdata;
        end
        if (last_beat) begin
            if (victim_q) tag1[idx_a] <= tag_a;
            else          tag0[idx_a] <= tag_a;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && hit_cnt != {CNT_W{1'b1}})   hit_cnt  <= hit_cnt + 1'b1;
            if (miss && miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// Self-checking bench for cache_assoc: scoreboard of expected read data,
// a bench-side memory model answering refills, and a counter model that
// follows CACHE_PERF_CNT_EN.
module tb_cache_assoc;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [14:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        hit, miss;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] sb_q[$];
    bit pat[$];

    cache_assoc #(.ADDR_W(15), .DATA_W(32), .INDEX_W(6), .OFFSET_W(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .hit(hit), .miss(miss),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [14:0] a);
        if (a[14:2] == 13'h100) return 32'hA0 + {30'd0, a[1:0]};
        return 32'hC0DE_0000 | {17'd0, a};
    endfunction

    function automatic logic [CNT_W-1:0] cnt_model(input int n);
`ifdef CACHE_PERF_CNT_EN
        return (n > 15) ? 4'd15 : n[CNT_W-1:0];
`else
        return (n > 0) ? 4'd0 : 4'd0;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_hits = 0; exp_misses = 0;
        sb_q.delete();
    endtask

    // Issue one read, answer any refill with pattern 'pat', check the response.
    task automatic do_read(input logic [14:0] a, input bit exp_miss, input bit noise);
        int cyc, beats, misses, mreq, hits, pidx;
        bit done, v;
        logic [31:0] exp;
        cyc = 0; beats = 0; misses = 0; mreq = 0; hits = 0; pidx = 0; done = 0; exp = '0;
        while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        req_valid = 1'b1; req_addr = a; sb_q.push_back(model_word(a));
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            cyc++;
            if (miss) begin
                misses++;
                checks++;
                if (hit || resp_valid) begin
                    errors++; $display("FAIL miss_excl addr=%h hit=%b resp_valid=%b want 0 0", a, hit, resp_valid);
                end
            end
            if (hit) hits++;
            if (mem_req) begin
                mreq++;
                checks++;
                if (mem_addr !== {a[14:2], 2'b00}) begin
                    errors++; $display("FAIL mem_addr got=%h want=%h", mem_addr, {a[14:2], 2'b00});
                end
                v = (pidx < pat.size()) ? pat[pidx] : 1'b1;
                pidx++;
                mem_rvalid = v;
                mem_rdata  = v ? model_word({a[14:2], beats[1:0]}) : 32'hDEAD_BEEF;
                if (v) beats++;
            end else begin
                mem_rvalid = noise;
                mem_rdata  = 32'hBAD0_0000 | cyc;
            end
            if (resp_valid) begin
                done = 1'b1;
                exp = sb_q.pop_front();
                checks++;
                if (resp_data !== exp || hit !== 1'b1 || miss !== 1'b0) begin
                    errors++; $display("FAIL resp addr=%h got data=%h hit=%b miss=%b want data=%h hit=1 miss=0", a, resp_data, hit, miss, exp);
                end
                checks++;
                if (misses != (exp_miss ? 1 : 0) || hits != 1) begin
                    errors++; $display("FAIL pulses addr=%h misses=%0d hits=%0d want %0d 1", a, misses, hits, exp_miss);
                end
                checks++;
                if (exp_miss ? (beats != 4) : (mreq != 0 || cyc != 2)) begin
                    errors++; $display("FAIL timing addr=%h beats=%0d mem_req_cycles=%0d lat=%0d", a, beats, mreq, cyc);
                end
            end else begin
                @(negedge clk);
            end
        end
        mem_rvalid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout addr=%h no resp_valid within budget", a);
            sb_q.delete();
        end else begin
            exp_hits++;
            if (exp_miss) exp_misses++;
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || resp_data !== exp) begin
                errors++; $display("FAIL hold got valid=%b data=%h want 0 %h", resp_valid, resp_data, exp);
            end
            checks++;
            if (hit_cnt !== cnt_model(exp_hits) || miss_cnt !== cnt_model(exp_misses)) begin
                errors++; $display("FAIL counters got hit=%0d miss=%0d want %0d %0d", hit_cnt, miss_cnt, cnt_model(exp_hits), cnt_model(exp_misses));
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || hit !== 1'b0 || miss !== 1'b0 ||
            mem_req !== 1'b0 || mem_addr !== '0 || resp_data !== '0 || hit_cnt !== '0 || miss_cnt !== '0) begin
            errors++;
            $display("FAIL reset rdy=%b rv=%b hit=%b miss=%b mreq=%b maddr=%h rdata=%h hc=%0d mc=%0d want 1 0 0 0 0 0 0 0 0",
                     req_ready, resp_valid, hit, miss, mem_req, mem_addr, resp_data, hit_cnt, miss_cnt);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic_miss();
        do_read(15'h0400, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_read(15'h0401, 1'b0, 1'b1);
        do_read(15'h0402, 1'b0, 1'b1);
        do_read(15'h0403, 1'b0, 1'b1);
    endtask

    task automatic test_lru();
        do_reset();
        do_read(15'h0000, 1'b1, 1'b0);
        do_read(15'h0100, 1'b1, 1'b0);
        do_read(15'h0000, 1'b0, 1'b0);
        do_read(15'h0200, 1'b1, 1'b0);
        do_read(15'h0000, 1'b0, 1'b0);
        do_read(15'h0100, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        do_reset();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_read(15'h0400, 1'b1, 1'b0);
        pat.delete();
        for (int i = 1; i < 4; i++) do_read(15'h0400 + 15'(i), 1'b0, 1'b0);
    endtask

    task automatic test_reset_refill();
        int beats, cyc;
        beats = 0; cyc = 0;
        do_reset();
        req_valid = 1'b1; req_addr = 15'h0400;
        @(negedge clk);
        req_valid = 1'b0;
        while (beats < 2 && cyc < 20) begin
            if (mem_req) begin
                mem_rvalid = 1'b1; mem_rdata = model_word({13'h100, beats[1:0]}); beats++;
            end
            @(negedge clk);
            cyc++;
        end
        mem_rvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (beats != 2 || mem_req !== 1'b0 || req_ready !== 1'b1 || miss_cnt !== '0) begin
            errors++; $display("FAIL abort beats=%0d mem_req=%b req_ready=%b miss_cnt=%0d want 2 0 1 0", beats, mem_req, req_ready, miss_cnt);
        end
        rst = 1'b1;
        exp_hits = 0; exp_misses = 0;
        do_read(15'h0400, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        do_reset();
        do_read(15'h0400, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) do_read(15'h0400 + 15'(i % 4), 1'b0, 1'b0);
        checks++;
        if (hit_cnt !== cnt_model(17)) begin
            errors++; $display("FAIL saturate hit_cnt=%0d want %0d", hit_cnt, cnt_model(17));
        end
    endtask

    initial begin
        test_reset();
        test_basic_miss();
        test_back_to_back();
        test_lru();
        test_stall();
        test_reset_refill();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
